// File: rtl/encoder_pkg.sv
// Shared constants for the priority-encoder family.
// Mode encodings are fixed so all encoder blocks agree on the meaning of the mode pin.
package encoder_pkg;

  localparam logic MODE_HIGH_FIRST = 1'b0;
  localparam logic MODE_LOW_FIRST  = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// Combinational priority pick: highest or lowest set bit of vec, selected by mode.
// Zero latency, no flow control; idx is 0 and found is 0 when vec is empty.
module prio_pick
  import encoder_pkg::*;
#(
  parameter int OUT_W = 3
) (
  input  logic [2**OUT_W-1:0] vec,
  input  logic                mode,
  output logic [OUT_W-1:0]    idx,
  output logic                found
);

  localparam int N = 2**OUT_W;

  // Scan order decides the winner: the last set bit visited overwrites earlier ones.
  always_comb begin
    idx   = '0;
    found = |vec;
    if (mode == MODE_LOW_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = OUT_W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = OUT_W'(i);
      end
    end
  end

endmodule

// File: rtl/prio_encoder_q.sv
// Queued priority encoder: accumulates request lines, grants one index per load into a valid/ready output register.
// One cycle req->pending, one more pending->out_valid; output holds stable while out_valid & !out_ready.
module prio_encoder_q
  import encoder_pkg::*;
#(
  parameter  int OUT_W = 3,
  localparam int N     = 2**OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_idx,
  output logic [N-1:0]     pending,
  output logic             any
);

  logic [OUT_W-1:0] pick_idx;
  logic             pick_found;
  logic             load;
  logic [N-1:0]     clr;
  logic [N-1:0]     pending_nxt;

  prio_pick #(
    .OUT_W (OUT_W)
  ) u_pick (
    .vec   (pending),
    .mode  (mode),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign any  = |pending;
  assign load = (!out_valid || out_ready) && pick_found;

  // A new request on the granted line re-arms it, so set wins over clear.
  always_comb begin
    clr = '0;
    if (load) clr[pick_idx] = 1'b1;
    pending_nxt = (pending & ~clr) | ({N{en}} & req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      pending <= pending_nxt;
      if (load) begin
        out_valid <= 1'b1;
        out_idx   <= pick_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_q.sv
// Self-checking bench for prio_encoder_q (OUT_W=3): directed scenarios plus randomized traffic against a reference model.
module tb_prio_encoder_q;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       mode = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic       any;

  int checks = 0;
  int passes = 0;

  prio_encoder_q #(.OUT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .mode      (mode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .any       (any)
  );

  always #5 clk = ~clk;

  // Reference model: pending set plus one output slot, picks via log2 arithmetic.
  function automatic int hi_bit(input logic [7:0] v);
    return $clog2(int'(v) + 1) - 1;
  endfunction

  function automatic int lo_bit(input logic [7:0] v);
    int x;
    x = int'(v);
    return $clog2(x & -x);
  endfunction

  logic [7:0] m_pending;
  logic       m_valid;
  logic [2:0] m_idx;
  logic       m_take;
  int         m_pick;
  logic [7:0] m_grant;

  always_comb begin
    m_take  = (!m_valid || out_ready) && (m_pending != 8'h00);
    m_pick  = 0;
    m_grant = 8'h00;
    if (m_take) begin
      m_pick  = mode ? lo_bit(m_pending) : hi_bit(m_pending);
      m_grant = 8'h01 << m_pick;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending <= 8'h00;
      m_valid   <= 1'b0;
      m_idx     <= 3'd0;
    end else begin
      m_pending <= (m_pending & ~m_grant) | (en ? req : 8'h00);
      if (m_take) begin
        m_valid <= 1'b1;
        m_idx   <= 3'(m_pick);
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; req = 8'h00; mode = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (pending !== 8'h00) $display("FAIL reset_pending got %h want 00", pending); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passes++;
    checks++; if (out_idx !== 3'd0) $display("FAIL reset_idx got %0d want 0", out_idx); else passes++;
    checks++; if (any !== 1'b0) $display("FAIL reset_any got %b want 0", any); else passes++;
    do_reset();
  endtask

  task automatic test_order(input logic m, input logic [2:0] first, input logic [2:0] second);
    do_reset();
    en = 1'b1; mode = m; out_ready = 1'b1; req = 8'hA0;
    tick();
    req = 8'h00;
    checks++; if (pending !== 8'hA0) $display("FAIL order_capture mode=%b got %h want a0", m, pending); else passes++;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== first) $display("FAIL order_first mode=%b got v=%b idx=%0d want v=1 idx=%0d", m, out_valid, out_idx, first); else passes++;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== second) $display("FAIL order_second mode=%b got v=%b idx=%0d want v=1 idx=%0d", m, out_valid, out_idx, second); else passes++;
    tick();
    checks++; if (out_valid !== 1'b0 || pending !== 8'h00) $display("FAIL order_drain mode=%b got v=%b pend=%h want v=0 pend=00", m, out_valid, pending); else passes++;
  endtask

  task automatic test_stall();
    do_reset();
    en = 1'b1; mode = 1'b0; out_ready = 1'b0; req = 8'h08;
    tick();
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd3) $display("FAIL stall_first got v=%b idx=%0d want v=1 idx=3", out_valid, out_idx); else passes++;
    req = 8'h48;
    mode = 1'b1;
    tick();
    mode = 1'b0;
    req = 8'h08;
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd3) $display("FAIL stall_hold got v=%b idx=%0d want v=1 idx=3", out_valid, out_idx); else passes++;
    checks++; if (pending !== 8'h48) $display("FAIL stall_pending got %h want 48", pending); else passes++;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd6) $display("FAIL stall_release got v=%b idx=%0d want v=1 idx=6", out_valid, out_idx); else passes++;
    req = 8'h00;
    tick();
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd3) $display("FAIL stall_recapture got v=%b idx=%0d want v=1 idx=3", out_valid, out_idx); else passes++;
    tick();
    checks++; if (out_valid !== 1'b0 || pending !== 8'h00) $display("FAIL stall_drain got v=%b pend=%h want v=0 pend=00", out_valid, pending); else passes++;
  endtask

  task automatic test_en_low();
    do_reset();
    en = 1'b0; req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pending !== 8'h00 || out_valid !== 1'b0) $display("FAIL en_low cyc=%0d got pend=%h v=%b want pend=00 v=0", i, pending, out_valid); else passes++;
    end
  endtask

  task automatic test_set_dominates();
    do_reset();
    en = 1'b1; req = 8'h08; out_ready = 1'b1; mode = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_idx !== 3'd3 || pending !== 8'h08) $display("FAIL set_dom cyc=%0d got v=%b idx=%0d pend=%h want v=1 idx=3 pend=08", i, out_valid, out_idx, pending); else passes++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; req = 8'h81; mode = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    req = 8'h00;
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd7 || pending !== 8'h81) $display("FAIL arst_setup got v=%b idx=%0d pend=%h want v=1 idx=7 pend=81", out_valid, out_idx, pending); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_idx !== 3'd0 || pending !== 8'h00 || any !== 1'b0) $display("FAIL arst_immediate got v=%b idx=%0d pend=%h any=%b want all 0", out_valid, out_idx, pending, any); else passes++;
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || any !== 1'b0) $display("FAIL arst_after cyc=%0d got v=%b any=%b want 0 0", i, out_valid, any); else passes++;
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      req       = 8'($urandom) & 8'($urandom) & 8'($urandom);
      mode      = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if (out_valid !== m_valid || pending !== m_pending || any !== (m_pending != 8'h00) ||
          (m_valid && out_idx !== m_idx)) begin
        if (errs < 10) $display("FAIL random cyc=%0d got v=%b idx=%0d pend=%h any=%b want v=%b idx=%0d pend=%h",
                                i, out_valid, out_idx, pending, any, m_valid, m_idx, m_pending);
        errs++;
      end else begin
        passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_order(1'b0, 3'd7, 3'd5);
    test_order(1'b1, 3'd5, 3'd7);
    test_stall();
    test_en_low();
    test_set_dominates();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/prio_encoder_q.md
PRIO_ENCODER_Q -- requirements
Module: prio_encoder_q

Interface
REQ-001 SHALL have parameter: OUT_W, default 3, index width; input count N = 2**OUT_W (derived, not overridable).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: en  input  1  capture enable for req.
REQ-005 SHALL have port: req  input  N  request lines, level-sampled.
REQ-006 SHALL have port: mode  input  1  0 = highest index first, 1 = lowest index first.
REQ-007 SHALL have port: out_ready  input  1  consumer accepts out_idx.
REQ-008 SHALL have port: out_valid  output  1  out_idx holds a granted index.
REQ-009 SHALL have port: out_idx  output  OUT_W  granted request index, binary.
REQ-010 SHALL have port: pending  output  N  registered pending-request vector.
REQ-011 SHALL have port: any  output  1  OR-reduction of pending, combinational from the register.

Function
REQ-012 Capture: each edge with en=1, pending <= (pending & ~clr) | req; with en=0, pending <= pending & ~clr (req ignored).
REQ-013 Load condition: load = (!out_valid | out_ready) & (pending != 0).
REQ-014 On load, out_idx <= pick(pending, mode) and out_valid <= 1; clr = one-hot of that index; otherwise clr = 0.
REQ-015 pick: mode 0 selects highest set bit, mode 1 selects lowest set bit; exactly one index per load.
REQ-016 Set dominates clear: a bit granted on an edge where en=1 and req at that bit = 1 remains pending.
REQ-017 Handshake: transfer occurs on an edge where out_valid=1 and out_ready=1; a transfer without a load sets out_valid <= 0.
REQ-018 While out_valid=1 and out_ready=0, out_idx and out_valid SHALL hold stable regardless of req, en or mode.
REQ-019 Back-to-back: with out_ready held 1, one index SHALL issue per cycle until pending is empty.
REQ-020 Latency: req asserted before edge k with en=1 and idle output -> pending set after edge k, out_valid after edge k+1.
REQ-021 mode is sampled only at load; a change mid-stream affects the next load only.
REQ-022 Duplicate requests for a bit already pending or in the output register SHALL NOT be counted; pending is one bit per line.
REQ-023 en=0 SHALL NOT block loads or handshakes of already-pending requests.

Reset
REQ-024 rst=1 SHALL immediately force pending=0, out_valid=0, out_idx=0, any=0, independent of clk.
REQ-025 Reset mid-handshake SHALL discard the in-flight index and all pending requests; no output after release until new req is captured.

Structure
REQ-026 SHALL take MODE_HIGH_FIRST=1'b0 and MODE_LOW_FIRST=1'b1 from shared package encoder_pkg.
REQ-027 SHALL instantiate one combinational sub-module prio_pick (parameter OUT_W; inputs vec, mode; outputs idx, found), reused by later encoder blocks.
REQ-028 All registers SHALL be in a single always block sensitive to clk and rst.

Verification (OUT_W=3)
REQ-029 req=8'hA0 for one cycle, en=1, mode=0, out_ready=1 -> out_idx 7 then 5 on consecutive cycles, then out_valid=0, pending=8'h00.
REQ-030 Same stimulus with mode=1 -> out_idx 5 then 7.
REQ-031 req=8'h08 held, out_ready=0 -> out_idx=3 stable; pulse req=8'h40 -> out_idx stays 3, pending=8'h48; raise out_ready -> next out_idx=6, then 3 (re-captured).
REQ-032 en=0, req=8'hFF for 4 cycles -> pending=8'h00, out_valid=0 throughout.
REQ-033 req[3] held high, en=1, out_ready=1 -> out_idx=3 every cycle, out_valid continuously 1 (set dominates).
REQ-034 rst pulsed asynchronously between edges while out_valid=1, pending=8'h81 -> all outputs 0 before next edge; no output after release with req=0.
